audio_echo_delay: RTL and testbench

- Sample-domain stage between the ADC capture stage and the DAC load stage in the audio path. Sits on the same slow clock as both.
- Accepts each 12-bit sample produced by the ADC stage and stores it in a circular delay buffer.
- Emits either the sample unchanged (bypass) or the average of the sample and the sample captured `delay` samples earlier (echo). The output feeds the DAC data input.

---
 rtl/audio_echo_delay_if.sv | 26 ++
 rtl/audio_echo_delay.sv | 101 ++++++++++
 tb/tb_audio_echo_delay.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/audio_echo_delay_if.sv
// Sample-stream bundle between the ADC stage, the echo/delay stage and the DAC stage.
// The driving side owns in_*/echo_en/delay; the echo stage owns out_*/busy/dropped/state_dbg.
interface audio_echo_delay_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              echo_en;
  logic [ADDR_W-1:0] delay;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              dropped;
  logic [1:0]        state_dbg;

  modport master (
    output in_data, in_valid, echo_en, delay,
    input  out_data, out_valid, busy, dropped, state_dbg
  );

  modport slave (
    input  in_data, in_valid, echo_en, delay,
    output out_data, out_valid, busy, dropped, state_dbg
  );
endinterface

// File: rtl/audio_echo_delay.sv
// Echo/delay stage: stores each sample in a circular buffer and emits either the sample
// or the truncating average of the sample and the one captured `delay` samples earlier.
module audio_echo_delay #(
  parameter int                DATA_W   = 12,
  parameter int                ADDR_W   = 10,
  parameter logic [DATA_W-1:0] MIDSCALE = 12'h800
) (
  input  logic             clock,
  input  logic             reset_n,
  audio_echo_delay_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  // Handshake: in_valid is a one-cycle pulse with no back-pressure; a pulse seen while
  // busy is discarded and flagged in dropped. out_valid pulses once per accepted sample,
  // in the same cycle that out_data takes its new value; out_data holds otherwise.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, MIX = 2'd2, WR = 2'd3} state_t;

  state_t            state;
  logic [DATA_W-1:0] sample_l;
  logic              echo_en_l;
  logic [ADDR_W-1:0] delay_l;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              dropped_r;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] dly;
  logic [DATA_W:0]   sum;

  // Natural ADDR_W-bit wrap gives the modulo-DEPTH distance across the wr_ptr wrap.
  assign rd_addr = wr_ptr - delay_l;

  always_comb begin
    dly = MIDSCALE;
    if (fill >= {1'b0, delay_l}) dly = rd_data;
    sum = {1'b0, sample_l} + {1'b0, dly};
  end

  // Buffer RAM has no reset; while reset is held the FSM sits in IDLE so nothing is written.
  always_ff @(posedge clock) begin
    if (state == RD) rd_data <= mem[rd_addr];
    if (state == WR) mem[wr_ptr] <= sample_l;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sample_l    <= '0;
      echo_en_l   <= 1'b0;
      delay_l     <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      out_data_r  <= MIDSCALE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (bus.in_valid && state != IDLE) dropped_r <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sample_l  <= bus.in_data;
            echo_en_l <= bus.echo_en;
            delay_l   <= bus.delay;
            busy_r    <= 1'b1;
            state     <= RD;
          end
        end
        RD: state <= MIX;
        MIX: begin
          // delay 0 would read a slot not yet written this round, so it is forced to bypass.
          if (echo_en_l && delay_l != '0) out_data_r <= sum[DATA_W:1];
          else                            out_data_r <= sample_l;
          out_valid_r <= 1'b1;
          state       <= WR;
        end
        WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != FULL) fill <= fill + 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.dropped   = dropped_r;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_audio_echo_delay.sv
// Directed bench for audio_echo_delay: reset/abort, fill-phase midscale substitution,
// bypass, impulse echo, overrun drop, and buffer wrap on a small (ADDR_W=3) instance.
module tb_audio_echo_delay;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  audio_echo_delay_if #(.DATA_W(12), .ADDR_W(10)) bus ();
  audio_echo_delay_if #(.DATA_W(12), .ADDR_W(3))  wbus ();

  audio_echo_delay #(.DATA_W(12), .ADDR_W(10), .MIDSCALE(12'h800)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );
  audio_echo_delay #(.DATA_W(12), .ADDR_W(3), .MIDSCALE(12'h800)) dut_w (
    .clock(clock), .reset_n(reset_n), .bus(wbus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one sample, then waits (bounded) for out_valid and checks data, latency, busy.
  task automatic send(input bit sel, input logic [11:0] d, input logic en,
                      input logic [9:0] dl, input logic [11:0] exp, input string tag);
    int lat = 0;
    int bsy = 0;
    logic seen = 1'b0;
    logic [11:0] got = '0;
    @(posedge clock); #1;
    if (sel) begin
      wbus.in_data = d; wbus.echo_en = en; wbus.delay = dl[2:0]; wbus.in_valid = 1'b1;
    end else begin
      bus.in_data = d; bus.echo_en = en; bus.delay = dl; bus.in_valid = 1'b1;
    end
    @(posedge clock); #1;
    wbus.in_valid = 1'b0;
    bus.in_valid  = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clock);
      if (sel ? wbus.busy : bus.busy) bsy++;
      if (sel ? wbus.out_valid : bus.out_valid) begin
        seen = 1'b1;
        lat  = i;
        got  = sel ? wbus.out_data : bus.out_data;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_data"}, 32'(got), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_busy"}, 32'(bsy), 32'd3);
  endtask

  initial begin
    int ov_cnt;
    logic [11:0] ov_data;
    bus.in_data = '0;  bus.in_valid = 1'b0;  bus.echo_en = 1'b0;  bus.delay = '0;
    wbus.in_data = '0; wbus.in_valid = 1'b0; wbus.echo_en = 1'b0; wbus.delay = '0;

    // Reset values
    #12;
    check("rst_out_data", 32'(bus.out_data), 32'h800);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dropped", 32'(bus.dropped), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Abort a sample mid-RD with reset
    @(posedge clock); #1;
    bus.in_data = 12'h111; bus.echo_en = 1'b1; bus.delay = 10'd3; bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check("abort_in_rd", 32'(bus.state_dbg), 32'd1);
    reset_n = 1'b0; #1;
    check("abort_out_data", 32'(bus.out_data), 32'h800);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dropped", 32'(bus.dropped), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    reset_n = 1'b1;

    // Fill phase: unwritten entries read as midscale; the aborted sample left no trace
    send(1'b0, 12'hC00, 1'b1, 10'd3, 12'hA00, "fill0");
    send(1'b0, 12'hC00, 1'b1, 10'd3, 12'hA00, "fill1");
    send(1'b0, 12'hC00, 1'b1, 10'd3, 12'hA00, "fill2");
    send(1'b0, 12'h400, 1'b1, 10'd3, 12'h800, "fill3");

    // Bypass
    send(1'b0, 12'h123, 1'b0, 10'd5, 12'h123, "byp0");
    send(1'b0, 12'hFFF, 1'b0, 10'd5, 12'hFFF, "byp1");
    send(1'b0, 12'h000, 1'b0, 10'd5, 12'h000, "byp2");

    // delay 0 with echo on is a pass-through
    send(1'b0, 12'h7A5, 1'b1, 10'd0, 12'h7A5, "dly0");

    // Impulse: prime history with silence, then FFF followed by silence at delay 4
    for (int i = 0; i < 4; i++) send(1'b0, 12'h800, 1'b0, 10'd4, 12'h800, "prime");
    exp_q = '{12'hBFF, 12'h800, 12'h800, 12'h800, 12'hBFF, 12'h800, 12'h800};
    send(1'b0, 12'hFFF, 1'b1, 10'd4, exp_q.pop_front(), "imp0");
    for (int i = 1; i < 7; i++) send(1'b0, 12'h800, 1'b1, 10'd4, exp_q.pop_front(), "imp");

    // Overrun: second pulse two cycles later lands in MIX and is dropped
    ov_cnt = 0;
    ov_data = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      bus.in_valid = (i == 0 || i == 2);
      bus.in_data  = (i == 0) ? 12'h5A5 : 12'h3C3;
      bus.echo_en  = 1'b0;
      @(negedge clock);
      if (bus.out_valid) begin
        ov_cnt++;
        ov_data = bus.out_data;
      end
    end
    bus.in_valid = 1'b0;
    check("ovr_count", 32'(ov_cnt), 32'd1);
    check("ovr_data", 32'(ov_data), 32'h5A5);
    check("ovr_dropped", 32'(bus.dropped), 32'd1);
    send(1'b0, 12'h246, 1'b0, 10'd2, 12'h246, "ovr_after");
    check("ovr_sticky", 32'(bus.dropped), 32'd1);

    // Wrap: fresh reset, 8-entry buffer, delay 7, ramp 0..19
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock);
    check("wrap_rst_dropped", 32'(bus.dropped), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k < 7) exp_q.push_back(12'((k + 12'h800) >> 1));
      else       exp_q.push_back(12'((k + (k - 7)) >> 1));
    end
    for (int k = 0; k < 20; k++) send(1'b1, 12'(k), 1'b1, 10'd7, exp_q.pop_front(), "wrap");
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
